// File: rtl/data_bus.sv
// data_bus: data-side bus for the pipelined core -- word RAM plus memory-mapped switches,
// LEDs, hex register, cycle counter and an optional UART transmitter (`define DATA_BUS_UART_EN).
module data_bus #(
   parameter int RAM_WORDS    = 256,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] memory_address,
   input  logic [31:0] memory_write_value,
   input  logic        memory_write_enable,
   output logic [31:0] memory_read_value,
   input  logic [17:0] SW,
   output logic [8:0]  LEDG,
   output logic [31:0] hex_value,
   output logic        uart_tx
);
   localparam int          AW            = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [31:0] RAM_LIMIT     = RAM_WORDS;
   localparam logic [5:0]  OFF_SW        = 6'h00;
   localparam logic [5:0]  OFF_LEDG      = 6'h01;
   localparam logic [5:0]  OFF_HEX       = 6'h02;
   localparam logic [5:0]  OFF_CYCLES    = 6'h03;
   localparam logic [5:0]  OFF_UART_DATA = 6'h04;
   localparam logic [5:0]  OFF_UART_STAT = 6'h05;

   logic [13:0]   w_word_idx;
   logic [AW-1:0] w_ram_idx;
   logic          w_ram_sel;
   logic          w_io_sel;
   logic [5:0]    w_io_off;
   logic          w_ram_wr;
   logic          w_ledg_wr;
   logic          w_hex_wr;
   logic          w_cyc_wr;
   logic          w_unused;

   logic [31:0]   r_ram [RAM_WORDS];
   logic [17:0]   r_sw_meta;
   logic [17:0]   r_sw_sync;
   logic [8:0]    r_ledg;
   logic [31:0]   r_hex;
   logic [31:0]   r_cycles;

   // Byte-offset bits [1:0] never take part in decode.
   assign w_unused   = &{1'b0, memory_address[1:0]};
   assign w_word_idx = memory_address[15:2];
   assign w_ram_idx  = w_word_idx[AW-1:0];
   assign w_ram_sel  = (memory_address[31:16] == 16'h0000) && ({18'd0, w_word_idx} < RAM_LIMIT);
   assign w_io_sel   = (memory_address[31:8] == 24'hFFFF00);
   assign w_io_off   = memory_address[7:2];
   assign w_ram_wr   = memory_write_enable && w_ram_sel;
   assign w_ledg_wr  = memory_write_enable && w_io_sel && (w_io_off == OFF_LEDG);
   assign w_hex_wr   = memory_write_enable && w_io_sel && (w_io_off == OFF_HEX);
   assign w_cyc_wr   = memory_write_enable && w_io_sel && (w_io_off == OFF_CYCLES);

   assign LEDG      = r_ledg;
   assign hex_value = r_hex;

   // RAM write port; contents deliberately not reset
   always_ff @(posedge clock) begin
      if (w_ram_wr) begin
         r_ram[w_ram_idx] <= memory_write_value;
      end
   end

   // Switch synchroniser, LED/hex registers and cycle counter (clear beats increment)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sw_meta <= 18'd0;
         r_sw_sync <= 18'd0;
         r_ledg    <= 9'd0;
         r_hex     <= 32'd0;
         r_cycles  <= 32'd0;
      end else begin
         r_sw_meta <= SW;
         r_sw_sync <= r_sw_meta;
         if (w_ledg_wr) begin
            r_ledg <= memory_write_value[8:0];
         end
         if (w_hex_wr) begin
            r_hex <= memory_write_value;
         end
         if (w_cyc_wr) begin
            r_cycles <= 32'd0;
         end else begin
            r_cycles <= r_cycles + 32'd1;
         end
      end
   end

`ifdef DATA_BUS_UART_EN
   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   uart_state_t   r_state;
   uart_state_t   w_state_next;
   logic [BW-1:0] r_baud;
   logic [BW-1:0] w_baud_next;
   logic [2:0]    r_bit_idx;
   logic [2:0]    w_bit_next;
   logic [7:0]    r_data;
   logic [7:0]    w_data_next;
   logic          r_tx;
   logic          w_tx_next;
   logic          w_uart_wr;
   logic          w_baud_done;
   logic          w_busy;

   assign w_uart_wr   = memory_write_enable && w_io_sel && (w_io_off == OFF_UART_DATA);
   assign w_baud_done = (r_baud == BAUD_LAST);
   assign w_busy      = (r_state != S_IDLE);
   assign uart_tx     = r_tx;

   // UART state register; the line level is registered from the next state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= 3'd0;
         r_data    <= 8'd0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_baud    <= w_baud_next;
         r_bit_idx <= w_bit_next;
         r_data    <= w_data_next;
         r_tx      <= w_tx_next;
      end
   end

   // UART next-state logic; only IDLE accepts a byte, so writes while busy drop out
   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_bit_next   = r_bit_idx;
      w_data_next  = r_data;
      w_tx_next    = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_baud_next = '0;
            if (w_uart_wr) begin
               w_state_next = S_START;
               w_data_next  = memory_write_value[7:0];
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_START: begin
            if (w_baud_done) begin
               w_state_next = S_DATA;
               w_baud_next  = '0;
               w_bit_next   = 3'd0;
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         S_DATA: begin
            if (w_baud_done) begin
               w_baud_next = '0;
               if (r_bit_idx == 3'd7) begin
                  w_state_next = S_STOP;
               end else begin
                  w_bit_next = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         S_STOP: begin
            if (w_baud_done) begin
               w_state_next = S_IDLE;
               w_baud_next  = '0;
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_baud_next  = '0;
         end
      endcase
      case (w_state_next)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = w_data_next[w_bit_next];
         default: w_tx_next = 1'b1;
      endcase
   end
`else
   assign uart_tx = 1'b1;
`endif

   // Combinational read mux
   always_comb begin
      memory_read_value = 32'd0;
      if (w_ram_sel) begin
         memory_read_value = r_ram[w_ram_idx];
      end else if (w_io_sel) begin
         case (w_io_off)
            OFF_SW:        memory_read_value = {14'd0, r_sw_sync};
            OFF_LEDG:      memory_read_value = {23'd0, r_ledg};
            OFF_HEX:       memory_read_value = r_hex;
            OFF_CYCLES:    memory_read_value = r_cycles;
`ifdef DATA_BUS_UART_EN
            OFF_UART_STAT: memory_read_value = {31'd0, w_busy};
`endif
            default:       memory_read_value = 32'd0;
         endcase
      end else begin
         memory_read_value = 32'd0;
      end
   end
endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed plus randomized accesses against a bench-side model.
module tb_data_bus;
   localparam int CPB = 4;
   localparam int RW  = 256;
   localparam logic [31:0] A_SW    = 32'hFFFF0000;
   localparam logic [31:0] A_LEDG  = 32'hFFFF0004;
   localparam logic [31:0] A_HEX   = 32'hFFFF0008;
   localparam logic [31:0] A_CYC   = 32'hFFFF000C;
   localparam logic [31:0] A_UDATA = 32'hFFFF0010;
   localparam logic [31:0] A_USTAT = 32'hFFFF0014;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rd;
   logic [17:0] sw;
   logic [8:0]  ledg;
   logic [31:0] hex;
   logic        tx;

   int vecs = 0;
   int errs = 0;

   logic [31:0] m_ram [RW];
   bit          m_valid [RW];

   data_bus #(.RAM_WORDS(RW), .CLKS_PER_BIT(CPB)) dut (
      .clock(clock), .reset(reset), .memory_address(addr), .memory_write_value(wdata),
      .memory_write_enable(we), .memory_read_value(rd), .SW(sw), .LEDG(ledg),
      .hex_value(hex), .uart_tx(tx)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected line level k cycles after a byte is accepted: start, 8 data LSB first, stop, idle.
   function automatic logic exp_tx(input logic [7:0] b, input int k);
      int slot;
      slot = k / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   // Called just after a falling edge; the store lands on the next rising edge.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      @(negedge clock);
      we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; sw = 18'h3FFFF; addr = A_SW; we = 1'b0; wdata = 32'd0;
      repeat (3) @(negedge clock);
      #1;
      vecs++; if (ledg !== 9'd0)     begin errs++; $display("FAIL rst_ledg got %h exp 0", ledg); end
      vecs++; if (hex !== 32'd0)     begin errs++; $display("FAIL rst_hex got %h exp 0", hex); end
      vecs++; if (tx !== 1'b1)       begin errs++; $display("FAIL rst_tx got %b exp 1", tx); end
      vecs++; if (rd !== 32'd0)      begin errs++; $display("FAIL rst_sw got %h exp 0", rd); end
      @(negedge clock);
      reset = 1'b0; addr = A_CYC; #1;
      vecs++; if (rd !== 32'd0)      begin errs++; $display("FAIL rst_cycles got %h exp 0", rd); end
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         @(negedge clock);
         a = (i == 0) ? A_LEDG : (i == 1) ? A_HEX : A_USTAT;
         addr = a; #1;
         vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL rst_read addr %h got %h exp 0", a, rd); end
      end
      vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL rst_tx_after got %b exp 1", tx); end
      @(negedge clock);
   endtask

   task automatic test_ram();
      logic [31:0] a;
      logic [31:0] d;
      int idx;
      do_write(32'h00000010, 32'hDEADBEEF);
      m_ram[4] = 32'hDEADBEEF; m_valid[4] = 1'b1;
      addr = 32'h00000010; #1;
      vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL ram_rd10 got %h exp deadbeef", rd); end
      addr = 32'h00000013; #1;
      vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL ram_rd13 got %h exp deadbeef", rd); end
      addr = 32'h00000400; #1;
      vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL ram_rd400 got %h exp 0", rd); end
      @(negedge clock);
      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(0, RW - 1);
         d = $urandom;
         a = {16'h0000, 6'd0, 8'(idx), 2'($urandom)};
         do_write(a, d);
         m_ram[idx] = d; m_valid[idx] = 1'b1;
         addr = a; #1;
         vecs++; if (rd !== d) begin errs++; $display("FAIL ram_wr_rd addr %h got %h exp %h", a, rd, d); end
      end
      for (int i = 0; i < RW; i++) begin
         if (m_valid[i]) begin
            @(negedge clock);
            addr = {16'h0000, 6'd0, 8'(i), 2'($urandom)}; #1;
            vecs++; if (rd !== m_ram[i]) begin errs++; $display("FAIL ram_scan idx %0d got %h exp %h", i, rd, m_ram[i]); end
         end
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         case (i % 3)
            0:       a = {16'h0000, 6'($urandom_range(1, 63)), 8'($urandom), 2'($urandom)};
            1:       a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
            default: a = {24'hFFFF00, 6'($urandom_range(6, 63)), 2'($urandom)};
         endcase
         d = $urandom;
         do_write(a, d);
         addr = a; #1;
         vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL unmapped addr %h got %h exp 0", a, rd); end
      end
      @(negedge clock);
   endtask

   task automatic test_switches();
      logic [17:0] prev;
      logic [17:0] nv;
      prev = sw;
      for (int i = 0; i < 5; i++) begin
         nv = (i == 0) ? 18'h2A5A5 : 18'($urandom);
         sw = nv; addr = A_SW;
         @(negedge clock); #1;
         vecs++; if (rd !== {14'd0, prev}) begin errs++; $display("FAIL sw_early got %h exp %h", rd, {14'd0, prev}); end
         repeat (2) @(negedge clock);
         #1;
         vecs++; if (rd !== {14'd0, nv}) begin errs++; $display("FAIL sw_sync got %h exp %h", rd, {14'd0, nv}); end
         prev = nv;
      end
      @(negedge clock);
      do_write(A_SW, 32'h0);
      addr = A_SW; #1;
      vecs++; if (rd !== {14'd0, prev}) begin errs++; $display("FAIL sw_readonly got %h exp %h", rd, {14'd0, prev}); end
      @(negedge clock);
   endtask

   task automatic test_leds_hex();
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = (i == 0) ? 32'h000001FF : $urandom;
         do_write(A_LEDG, d);
         addr = A_LEDG; #1;
         vecs++; if (ledg !== d[8:0]) begin errs++; $display("FAIL ledg_out got %h exp %h", ledg, d[8:0]); end
         vecs++; if (rd !== {23'd0, d[8:0]}) begin errs++; $display("FAIL ledg_rd got %h exp %h", rd, {23'd0, d[8:0]}); end
         @(negedge clock);
         d = $urandom;
         do_write(A_HEX, d);
         addr = A_HEX; #1;
         vecs++; if (hex !== d) begin errs++; $display("FAIL hex_out got %h exp %h", hex, d); end
         vecs++; if (rd !== d) begin errs++; $display("FAIL hex_rd got %h exp %h", rd, d); end
         @(negedge clock);
      end
   endtask

   task automatic test_cycles();
      repeat ($urandom_range(1, 9)) @(negedge clock);
      do_write(A_CYC, $urandom);
      addr = A_CYC;
      for (int k = 0; k < 3; k++) begin
         #1;
         vecs++; if (rd !== 32'(k)) begin errs++; $display("FAIL cycles_clear k %0d got %h exp %h", k, rd, 32'(k)); end
         @(negedge clock);
      end
      force dut.r_cycles = 32'hFFFFFFFF;
      #1;
      vecs++; if (rd !== 32'hFFFFFFFF) begin errs++; $display("FAIL cycles_max got %h exp ffffffff", rd); end
      release dut.r_cycles;
      @(negedge clock); #1;
      vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL cycles_wrap got %h exp 0", rd); end
      @(negedge clock); #1;
      vecs++; if (rd !== 32'd1) begin errs++; $display("FAIL cycles_after_wrap got %h exp 1", rd); end
      @(negedge clock);
   endtask

   task automatic test_uart();
`ifdef DATA_BUS_UART_EN
      logic [7:0] b;
      b = 8'h55;
      do_write(A_UDATA, {24'($urandom), b});
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 10 * CPB; k++) begin
            if (f == 0 && k == 10) begin
               addr = A_UDATA; wdata = 32'h000000FF; we = 1'b1;
            end else begin
               addr = A_USTAT; we = 1'b0;
            end
            #1;
            vecs++; if (tx !== exp_tx(b, k)) begin errs++; $display("FAIL uart_tx frame %0d k %0d got %b exp %b", f, k, tx, exp_tx(b, k)); end
            if (!(f == 0 && k == 10)) begin
               vecs++; if (rd !== 32'd1) begin errs++; $display("FAIL uart_busy frame %0d k %0d got %h exp 1", f, k, rd); end
            end
            @(negedge clock);
         end
         we = 1'b0; addr = A_USTAT; #1;
         vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL uart_idle_tx frame %0d got %b exp 1", f, tx); end
         vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL uart_idle_busy frame %0d got %h exp 0", f, rd); end
         if (f == 0) begin
            b = 8'($urandom);
            do_write(A_UDATA, {24'($urandom), b});
         end
      end
      addr = A_UDATA; #1;
      vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL uart_data_rd got %h exp 0", rd); end
      @(negedge clock);
`else
      do_write(A_UDATA, 32'h00000055);
      for (int k = 0; k < 20; k++) begin
         addr = (k % 2 == 0) ? A_USTAT : A_UDATA; #1;
         vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL uart_off_tx k %0d got %b exp 1", k, tx); end
         vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL uart_off_rd k %0d got %h exp 0", k, rd); end
         @(negedge clock);
      end
`endif
   endtask

   task automatic test_uart_reset();
`ifdef DATA_BUS_UART_EN
      logic [7:0] b;
      b = 8'($urandom);
      do_write(A_UDATA, {24'd0, b});
      addr = A_USTAT;
      for (int k = 0; k < 15; k++) begin
         #1;
         vecs++; if (tx !== exp_tx(b, k)) begin errs++; $display("FAIL uart_pre_rst k %0d got %b exp %b", k, tx, exp_tx(b, k)); end
         @(negedge clock);
      end
`endif
      reset = 1'b1; addr = A_USTAT; #1;
      vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL uart_rst_tx got %b exp 1", tx); end
      vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL uart_rst_busy got %h exp 0", rd); end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
`ifdef DATA_BUS_UART_EN
      b = 8'($urandom);
      do_write(A_UDATA, {24'd0, b});
      addr = A_USTAT;
      for (int k = 0; k <= 10 * CPB; k++) begin
         #1;
         vecs++; if (tx !== exp_tx(b, k)) begin errs++; $display("FAIL uart_post_rst k %0d got %b exp %b", k, tx, exp_tx(b, k)); end
         vecs++; if (rd !== ((k < 10 * CPB) ? 32'd1 : 32'd0)) begin errs++; $display("FAIL uart_post_rst_busy k %0d got %h", k, rd); end
         @(negedge clock);
      end
`else
      do_write(A_UDATA, 32'h000000A5);
      addr = A_USTAT; #1;
      vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL uart_off_post_rst got %b exp 1", tx); end
      @(negedge clock);
`endif
   endtask

   initial begin
      test_reset();
      test_ram();
      test_switches();
      test_leds_hex();
      test_cycles();
      test_uart();
      test_uart_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/data_bus.md
# data_bus

Data-side bus for the five-stage pipelined core. It sits directly downstream of the core's memory stage and consumes its `memory_address`, `memory_write_value` and `memory_write_enable` outputs. It returns `memory_read_value` combinationally within the same cycle. It decodes each access to word RAM or to memory-mapped I/O: switches, green LEDs, a hex-display register, a free-running cycle counter and a UART transmitter.

## Interface
Parameters:
- `RAM_WORDS`, default 256: depth of the data RAM in 32-bit words; must be a power of two.
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200).

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `memory_address`  in  32: byte address from the memory stage.
- `memory_write_value`  in  32: store data.
- `memory_write_enable`  in  1: store strobe, valid for the current cycle only.
- `memory_read_value`  out  32: combinational read data.
- `SW`  in  18: raw board switches; asynchronous to `clock`.
- `LEDG`  out  9: green LED register.
- `hex_value`  out  32: hex-display register, consumed by the display driver.
- `uart_tx`  out  1: serial output; idles high.

## Operation
Address decode:
- Bits [1:0] are ignored everywhere.
- RAM region: `address[31:16]==0` and `address[15:2] < RAM_WORDS`; RAM index = `address[15:2]`.
- I/O region: `address[31:8]==24'hFFFF00`, decoded on `address[7:0]`:
  - 0x00 SW: read-only, returns the synchronised switches zero-extended.
  - 0x04 LEDG: read/write, bits [8:0].
  - 0x08 HEX: read/write, 32 bits.
  - 0x0C CYCLES: read returns the counter; any write clears it.
  - 0x10 UART_DATA: a write transmits bits [7:0]; reads return 0.
  - 0x14 UART_STATUS: bit0 = busy; remaining bits 0.
- Any other address is unmapped: reads return 0, writes are ignored.

RAM:
- Read is asynchronous; write is synchronous.
- Contents are not reset.

Switches: two-flop synchroniser, reset to 0.

Cycle counter:
- 32-bit, increments every cycle and wraps from 0xFFFFFFFF to 0.
- A write clears it; the clear has priority over the increment.

UART transmitter FSM, states IDLE, START, DATA, STOP:
- IDLE: `uart_tx`=1 and busy=0. A write to UART_DATA latches the byte and moves to START.
- START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles, counted with a 3-bit bit index. After bit 7, move to STOP.
- STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- busy=1 in every state except IDLE.
- A write to UART_DATA while busy is dropped. It does not queue and does not corrupt the frame in flight.

Reset values: `LEDG`=0, `hex_value`=0, counter=0, UART in IDLE, `uart_tx`=1, busy=0, synchroniser=0. Asserting reset mid-frame forces `uart_tx` high and busy low immediately.

## Timing
- Reads:
  - Zero latency: `memory_read_value` is combinational from `memory_address` and current register/RAM state.
- Writes:
  - Take effect at the rising edge that samples `memory_write_enable`=1.
  - A read of the same location in the next cycle returns the new value.
- Cycle counter:
  - A counter write at edge N makes CYCLES read 0 in cycle N+1 and 1 in cycle N+2.
  - A CYCLES read returns the value before the current edge's increment.
- UART:
  - A write accepted at edge N gives busy=1 and `uart_tx`=0 from cycle N+1.
  - The frame lasts exactly 10×`CLKS_PER_BIT` cycles, after which busy=0.
  - A new write is accepted on the first cycle that busy reads 0.
- Switches: a `SW` change is visible on reads 2–3 cycles later.

## Configuration
- `DATA_BUS_UART_EN` defined: the UART FSM, baud counter and UART_DATA/UART_STATUS registers are compiled in, behaving as above.
- `DATA_BUS_UART_EN` undefined: no UART logic is built.
  - `uart_tx` is tied to 1.
  - UART_DATA and UART_STATUS behave as unmapped: read 0, writes ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read 0xFFFF0004, 0xFFFF0008, 0xFFFF0014 -> each reads 0; `uart_tx`=1.
- Write 0xDEADBEEF to 0x00000010, read it the next cycle -> 0xDEADBEEF. Read 0x00000013 -> 0xDEADBEEF. Read 0x00000400 (RAM_WORDS=256, unmapped) -> 0.
- Set `SW`=0x2A5A5, wait 3 cycles, read 0xFFFF0000 -> 0x0002A5A5. Write 0x1FF to 0xFFFF0004 -> `LEDG`=0x1FF next cycle.
- Write to 0xFFFF000C, then read over consecutive cycles -> 0, 1, 2. Force the counter to 0xFFFFFFFF -> it reads 0 on the next cycle.
- `CLKS_PER_BIT`=4, write 0x55 to 0xFFFF0010 -> `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles. busy stays 1 for exactly 40 cycles. A second write of 0xFF at cycle 10 is dropped.
- Assert reset at cycle 15 of a frame -> `uart_tx`=1 and busy=0 immediately. A write after reset starts a clean frame.
